// File: rtl/tetris_game_ctrl.sv
// Falling-piece sequencer: spawn, gravity, player moves and lock handshake
// with the playfield store; detects game over at spawn.
module tetris_game_ctrl #(
  parameter int DROP_TICKS = 50000000,
  parameter int SPAWN_X    = 3
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic       mv_left,
  input  logic       mv_right,
  input  logic       mv_rot,
  input  logic       mv_down,
  input  logic [2:0] rnd,
  input  logic       el,
  input  logic       er,
  input  logic       eu,
  input  logic       edrop,
  input  logic       overflow,
  input  logic       refresh_done,
  output logic [4:0] x,
  output logic [4:0] y,
  output logic [2:0] piece_type,
  output logic [1:0] dir,
  output logic       refresh,
  output logic       clear,
  output logic       game_over,
  output logic       busy
);

  localparam int CW = (DROP_TICKS > 2) ? $clog2(DROP_TICKS) : 1;
  localparam logic [CW-1:0] TMAX = CW'(DROP_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE, SPAWN, CHECK, FALL, LOCK, WAIT_REF, OVER
  } state_t;

  state_t state_q, state_d;
  logic [4:0] x_q, x_d, y_q, y_d;
  logic [2:0] type_q, type_d;
  logic [1:0] dir_q, dir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pend_q, pend_d;
  logic clear_q, clear_d;
  logic at_max, tick;

  assign at_max = (cnt_q == TMAX);
  // A tick beaten by a higher-priority move stays pending for one slot.
  assign tick = at_max | pend_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      type_q  <= '0;
      dir_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      type_q  <= type_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      clear_q <= clear_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    type_d  = type_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    clear_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          clear_d = 1'b1;
          state_d = SPAWN;
        end
      end
      SPAWN: begin
        x_d     = 5'(SPAWN_X);
        y_d     = '0;
        dir_d   = '0;
        type_d  = (rnd == 3'd7) ? 3'd0 : rnd;
        cnt_d   = '0;
        pend_d  = 1'b0;
        state_d = CHECK;
      end
      CHECK: state_d = overflow ? OVER : FALL;
      FALL: begin
        cnt_d  = at_max ? '0 : cnt_q + CW'(1);
        pend_d = tick;
        if (mv_rot) begin
          if (eu) dir_d = dir_q + 2'd1;
        end else if (mv_left) begin
          if (el) x_d = x_q - 5'd1;
        end else if (mv_right) begin
          if (er) x_d = x_q + 5'd1;
        end else if (mv_down || tick) begin
          pend_d = 1'b0;
          if (edrop) begin
            y_d   = y_q + 5'd1;
            cnt_d = '0;
          end else begin
            state_d = LOCK;
          end
        end
      end
      LOCK: state_d = WAIT_REF;
      WAIT_REF: begin
        if (refresh_done) state_d = SPAWN;
      end
      OVER: begin
        if (start) begin
          clear_d = 1'b1;
          state_d = SPAWN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign x          = x_q;
  assign y          = y_q;
  assign piece_type = type_q;
  assign dir        = dir_q;
  assign clear      = clear_q;
  assign refresh    = (state_q == LOCK);
  assign game_over  = (state_q == OVER);
  assign busy       = (state_q != IDLE) && (state_q != OVER);

endmodule

// File: tb/tb_tetris_game_ctrl.sv
// Directed bench for tetris_game_ctrl with DROP_TICKS=4, SPAWN_X=3.
module tb_tetris_game_ctrl;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 0, mv_left = 0, mv_right = 0, mv_rot = 0, mv_down = 0;
  logic [2:0] rnd = 3'd7;
  logic el = 1, er = 1, eu = 1, edrop = 1, overflow = 0, refresh_done = 0;
  logic [4:0] x, y;
  logic [2:0] piece_type;
  logic [1:0] dir;
  logic refresh, clear, game_over, busy;

  int total = 0;
  int bad = 0;

  tetris_game_ctrl #(.DROP_TICKS(4), .SPAWN_X(3)) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .mv_left(mv_left), .mv_right(mv_right),
    .mv_rot(mv_rot), .mv_down(mv_down), .rnd(rnd),
    .el(el), .er(er), .eu(eu), .edrop(edrop),
    .overflow(overflow), .refresh_done(refresh_done),
    .x(x), .y(y), .piece_type(piece_type), .dir(dir),
    .refresh(refresh), .clear(clear),
    .game_over(game_over), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    total++;
    if ({x, y, piece_type, dir} !== 15'd0) begin
      bad++;
      $display("FAIL reset_piece got=%h exp=0",
               {x, y, piece_type, dir});
    end
    total++;
    if ({refresh, clear, game_over, busy} !== 4'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=0000",
               {refresh, clear, game_over, busy});
    end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_spawn_gravity();
    start = 1;
    step();
    start = 0;
    total++;
    if (clear !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL spawn_clear got=%b%b exp=11", clear, busy);
    end
    step();
    total++;
    if (x !== 5'd3 || y !== 5'd0 || piece_type !== 3'd0
        || clear !== 1'b0) begin
      bad++;
      $display("FAIL spawn_piece got x=%0d y=%0d t=%0d c=%b exp 3 0 0 0",
               x, y, piece_type, clear);
    end
    step();
    for (int i = 0; i < 3; i++) step();
    total++;
    if (y !== 5'd0) begin
      bad++;
      $display("FAIL grav_early got=%0d exp=0", y);
    end
    step();
    total++;
    if (y !== 5'd1) begin
      bad++;
      $display("FAIL grav_step1 got=%0d exp=1", y);
    end
    for (int i = 0; i < 4; i++) step();
    total++;
    if (y !== 5'd2) begin
      bad++;
      $display("FAIL grav_step2 got=%0d exp=2", y);
    end
  endtask

  task automatic test_moves();
    mv_rot = 1;
    mv_left = 1;
    step();
    mv_rot = 0;
    mv_left = 0;
    total++;
    if (dir !== 2'd1 || x !== 5'd3) begin
      bad++;
      $display("FAIL rot_over_left got dir=%0d x=%0d exp 1 3", dir, x);
    end
    el = 0;
    mv_left = 1;
    step();
    mv_left = 0;
    el = 1;
    total++;
    if (x !== 5'd3) begin
      bad++;
      $display("FAIL left_refused got=%0d exp=3", x);
    end
    mv_right = 1;
    er = 1;
    mv_rot = 1;
    step();
    mv_rot = 0;
    mv_right = 0;
    total++;
    if (dir !== 2'd2 || x !== 5'd3) begin
      bad++;
      $display("FAIL rot_over_right got dir=%0d x=%0d exp 2 3", dir, x);
    end
    mv_rot = 1;
    step();
    mv_rot = 0;
    total++;
    if (dir !== 2'd3 || y !== 5'd2) begin
      bad++;
      $display("FAIL rot_beats_tick got dir=%0d y=%0d exp 3 2", dir, y);
    end
    step();
    total++;
    if (y !== 5'd3) begin
      bad++;
      $display("FAIL pending_tick got=%0d exp=3", y);
    end
    mv_rot = 1;
    step();
    mv_rot = 0;
    total++;
    if (dir !== 2'd0) begin
      bad++;
      $display("FAIL dir_wrap got=%0d exp=0", dir);
    end
  endtask

  task automatic test_back_to_back();
    step();
    mv_down = 1;
    step();
    mv_down = 0;
    total++;
    if (y !== 5'd4) begin
      bad++;
      $display("FAIL soft_drop got=%0d exp=4", y);
    end
    step();
    step();
    step();
    total++;
    if (y !== 5'd4) begin
      bad++;
      $display("FAIL no_double_step got=%0d exp=4", y);
    end
    step();
    total++;
    if (y !== 5'd5) begin
      bad++;
      $display("FAIL restart_tick got=%0d exp=5", y);
    end
    mv_right = 1;
    step();
    mv_right = 0;
    total++;
    if (x !== 5'd4) begin
      bad++;
      $display("FAIL right_move got=%0d exp=4", x);
    end
    mv_left = 1;
    step();
    mv_left = 0;
    total++;
    if (x !== 5'd3) begin
      bad++;
      $display("FAIL left_move got=%0d exp=3", x);
    end
  endtask

  task automatic test_lock();
    edrop = 0;
    step();
    total++;
    if (refresh !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL pre_lock got=%b%b exp=01", refresh, busy);
    end
    step();
    total++;
    if (refresh !== 1'b1 || y !== 5'd5 || x !== 5'd3) begin
      bad++;
      $display("FAIL lock got r=%b x=%0d y=%0d exp 1 3 5",
               refresh, x, y);
    end
    step();
    total++;
    if (refresh !== 1'b0) begin
      bad++;
      $display("FAIL refresh_1cyc got=%b exp=0", refresh);
    end
    for (int i = 0; i < 4; i++) step();
    total++;
    if (y !== 5'd5 || busy !== 1'b1 || refresh !== 1'b0) begin
      bad++;
      $display("FAIL wait_hold got y=%0d b=%b r=%b exp 5 1 0",
               y, busy, refresh);
    end
    rnd = 3'd5;
    edrop = 1;
    refresh_done = 1;
    step();
    refresh_done = 0;
    step();
    total++;
    if (y !== 5'd0 || piece_type !== 3'd5 || x !== 5'd3) begin
      bad++;
      $display("FAIL respawn got x=%0d y=%0d t=%0d exp 3 0 5",
               x, y, piece_type);
    end
  endtask

  task automatic test_over();
    step();
    edrop = 0;
    mv_down = 1;
    step();
    mv_down = 0;
    step();
    refresh_done = 1;
    overflow = 1;
    rnd = 3'd2;
    step();
    refresh_done = 0;
    step();
    step();
    total++;
    if (game_over !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL over got go=%b busy=%b exp 1 0", game_over, busy);
    end
    mv_left = 1;
    mv_rot = 1;
    mv_down = 1;
    refresh_done = 1;
    step();
    mv_left = 0;
    mv_rot = 0;
    mv_down = 0;
    refresh_done = 0;
    step();
    total++;
    if (x !== 5'd3 || dir !== 2'd0 || y !== 5'd0
        || piece_type !== 3'd2 || game_over !== 1'b1) begin
      bad++;
      $display("FAIL over_frozen got x=%0d d=%0d y=%0d t=%0d go=%b",
               x, dir, y, piece_type, game_over);
    end
    overflow = 0;
    edrop = 1;
    rnd = 3'd6;
    start = 1;
    step();
    start = 0;
    total++;
    if (game_over !== 1'b0 || clear !== 1'b1) begin
      bad++;
      $display("FAIL restart got go=%b clr=%b exp 0 1", game_over, clear);
    end
    step();
    total++;
    if (piece_type !== 3'd6 || y !== 5'd0 || clear !== 1'b0) begin
      bad++;
      $display("FAIL restart_spawn got t=%0d y=%0d c=%b exp 6 0 0",
               piece_type, y, clear);
    end
  endtask

  task automatic test_reset_wait_ref();
    step();
    edrop = 0;
    mv_down = 1;
    step();
    mv_down = 0;
    step();
    rstn = 0;
    #1;
    total++;
    if (x !== 5'd0 || y !== 5'd0 || busy !== 1'b0
        || refresh !== 1'b0 || game_over !== 1'b0) begin
      bad++;
      $display("FAIL rst_wait got x=%0d y=%0d b=%b r=%b go=%b",
               x, y, busy, refresh, game_over);
    end
    step();
    rstn = 1;
    edrop = 1;
    refresh_done = 1;
    step();
    refresh_done = 0;
    step();
    total++;
    if (busy !== 1'b0 || clear !== 1'b0 || x !== 5'd0) begin
      bad++;
      $display("FAIL rst_ignore_done got b=%b c=%b x=%0d exp 0 0 0",
               busy, clear, x);
    end
  endtask

  initial begin
    test_reset();
    test_spawn_gravity();
    test_moves();
    test_back_to_back();
    test_lock();
    test_over();
    test_reset_wait_ref();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tetris_game_ctrl.md
Name: tetris_game_ctrl

Overview:
Top-level sequencer for the playfield store. It owns the falling-piece registers (x, y, type, dir) that drive the store, applies gravity and player moves gated by the store's el/er/eu/edrop enables, and locks pieces with the refresh/refresh_done handshake. It detects game over at spawn and sits between the button debouncers/random source and the playfield store.

Parameters:
DROP_TICKS, 50000000, clk cycles between gravity steps (minimum 2)
SPAWN_X, 3, x coordinate loaded at spawn (0..6)

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a game from IDLE or OVER
mv_left  in  1  one-cycle pulse; move request
mv_right  in  1  one-cycle pulse; move request
mv_rot  in  1  one-cycle pulse; rotate request
mv_down  in  1  one-cycle pulse; soft-drop request
rnd  in  3  free-running random value, sampled at spawn
el, er, eu, edrop  in  1 each  store move enables (combinational from current x/y/type/dir)
overflow  in  1  high = spawned piece collides with occupied cells
refresh_done  in  1  one-cycle pulse from store; lock and line clear finished
x  out  5  piece column; reset 0
y  out  5  piece row; reset 0
type  out  3  piece type 0..6; reset 0
dir  out  2  rotation; reset 0
refresh  out  1  one-cycle lock request to store; reset 0
clear  out  1  one-cycle board-clear request; reset 0
game_over  out  1  level; reset 0
busy  out  1  high in every state except IDLE and OVER; reset 0

Behaviour:
- States: IDLE, SPAWN, CHECK, FALL, LOCK, WAIT_REF, OVER. Reset enters IDLE; all outputs take their reset values and the gravity counter is cleared. Asserting rstn in any state, including WAIT_REF, aborts the operation immediately.
- IDLE: start -> pulse clear for 1 cycle, go to SPAWN. All other inputs are ignored.
- SPAWN (1 cycle): x=SPAWN_X, y=0, dir=0, type=(rnd==7)?0:rnd; gravity counter cleared. Go to CHECK.
- CHECK (1 cycle; lets the store flags settle on the new piece): overflow=1 -> OVER; otherwise -> FALL.
- FALL: at most one action per cycle. Priority: mv_rot > mv_left > mv_right > mv_down > gravity tick.
  - rot: if eu, dir <= dir+1 (wraps 3->0).
  - left: if el, x <= x-1.
  - right: if er, x <= x+1.
  - down or tick: if edrop, y <= y+1 and the gravity counter clears; else go to LOCK.
  - A refused move changes nothing and is not retried; a lower-priority request in the same cycle is dropped.
  - The gravity counter increments every FALL cycle and the tick fires when it reaches DROP_TICKS-1. If a higher-priority action wins that cycle, the tick is held pending and serviced the next cycle with no other request.
- LOCK (1 cycle): refresh=1; go to WAIT_REF. x/y/type/dir are held stable through LOCK and WAIT_REF because the store writes the piece from them.
- WAIT_REF: wait for refresh_done, then go to SPAWN. No timeout. A refresh_done pulse in any other state is ignored.
- OVER: game_over=1 and x/y/type/dir are frozen. start -> game_over=0, pulse clear, go to SPAWN.
- Widths: x and y are 5-bit unsigned. Boundary legality comes entirely from the enables, so the block never clamps or wraps x/y itself.

Test Plan:
- Reset mid-WAIT_REF: rstn low for 1 cycle -> IDLE, refresh/clear/game_over=0, x=y=0; a later refresh_done is ignored.
- start with rnd=7, overflow=0, edrop=1, DROP_TICKS=4 -> clear pulse; x=3, y=0, type=0; y steps 0->1->2 every 4 cycles in FALL.
- In FALL, pulse mv_rot and mv_left in the same cycle with eu=1, el=1 -> dir 0->1, x unchanged; mv_left with el=0 -> x stays 3.
- edrop=0 on tick -> refresh high for exactly 1 cycle, x/y held; refresh_done 5 cycles later -> SPAWN then CHECK, y=0, type=rnd.
- overflow=1 in CHECK -> game_over=1, busy=0, buttons ignored; then start -> game_over=0, clear pulse, new spawn.
- dir=3 with eu=1, mv_rot -> dir=0; mv_down with edrop=1 one cycle before a tick -> y+1 and the counter restarts with no double step.
